// File: rtl/msp430_regfile.sv
// msp430_regfile: register file and operand-address datapath for the MSP430 core.
//
// Holds R0 (PC), R1 (SP), R2 (SR/CG1), R3 (CG2) and R4-R15. It drives the
// selected operand or effective address onto reg_out, and it performs
// post-increment, byte-mode write masking and SR bit masking.
//
// Optional feature macro: REGFILE_CONSTGEN_EN
//   defined   : R2/R3 act as constant generators, selected by As.
//   undefined : R2 is a plain SR for all As values, and R3 is a general register.
//
// Ports
//   clk        in   1  clock; all state updates on the rising edge
//   srst_n     in   1  synchronous active-low reset
//   regno      in   4  register select
//   As         in   2  source addressing mode
//   bytemode   in   1  byte operation (B/W)
//   reg_store  in   1  write data_in into R[regno] at the next edge
//   reg_inc    in   1  post-increment R[regno] at the next edge
//   data_in    in  16  write data from the operand bus
//   mdr        in  16  index word used when As=1
//   reg_out    out 16  combinational operand or effective address
//   pc_out     out 16  current R0
//   sr_out     out 16  current R2 & SR_MASK
module msp430_regfile #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] RESET_SP = 16'h0000,
  parameter logic [15:0] SR_MASK  = 16'h01FF
) (
  input  logic        clk,
  input  logic        srst_n,
  input  logic [3:0]  regno,
  input  logic [1:0]  As,
  input  logic        bytemode,
  input  logic        reg_store,
  input  logic        reg_inc,
  input  logic [15:0] data_in,
  input  logic [15:0] mdr,
  output logic [15:0] reg_out,
  output logic [15:0] pc_out,
  output logic [15:0] sr_out
);

  localparam int unsigned DW   = 16;
  localparam int unsigned NREG = 16;

  logic [DW-1:0] r_regs [NREG];

  logic [DW-1:0] w_rd_raw;
  logic [DW-1:0] w_rd;
  logic [DW-1:0] w_idx;
  logic [DW-1:0] w_step;
  logic [DW-1:0] w_store_val;
  logic          w_cg_reg;
  logic          w_wr_en;
  logic [DW-1:0] w_wr_val;

`ifdef REGFILE_CONSTGEN_EN
  assign w_cg_reg = (regno == 4'd2) || (regno == 4'd3);
`else
  assign w_cg_reg = 1'b0;
`endif

  // R2 is stored masked already; the read masks again so unused SR bits can never leak.
  assign w_rd_raw = r_regs[regno];
  assign w_rd     = (regno == 4'd2) ? (w_rd_raw & SR_MASK) : w_rd_raw;
  assign w_idx    = w_rd + mdr;

  assign pc_out = r_regs[0];
  assign sr_out = r_regs[2] & SR_MASK;

  // Operand / effective-address mux.
  always_comb begin
    reg_out = w_rd;
    if (w_cg_reg && (regno == 4'd3)) begin
      unique case (As)
        2'd0:    reg_out = 16'h0000;
        2'd1:    reg_out = 16'h0001;
        2'd2:    reg_out = 16'h0002;
        default: reg_out = 16'hFFFF;
      endcase
    end else if (w_cg_reg) begin
      unique case (As)
        2'd0:    reg_out = w_rd;
        2'd1:    reg_out = mdr;
        2'd2:    reg_out = 16'h0004;
        default: reg_out = 16'h0008;
      endcase
    end else if (As == 2'd1) begin
      reg_out = w_idx;
    end
  end

  // Byte steps only apply to general registers; PC/SP/SR/CG always step by a word.
  assign w_step      = (bytemode && (regno >= 4'd4)) ? 16'd1 : 16'd2;
  assign w_store_val = bytemode ? {8'h00, data_in[7:0]} : data_in;

  // Write-port selection: store beats increment because both share regno.
  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_val = w_rd_raw;
    if (reg_store) begin
      w_wr_en  = !(w_cg_reg && (regno == 4'd3));
      w_wr_val = w_store_val;
      if (regno <= 4'd1) begin
        w_wr_val[0] = 1'b0;
      end
    end else if (reg_inc && !w_cg_reg) begin
      w_wr_en  = 1'b1;
      w_wr_val = w_rd_raw + w_step;
    end
    if (regno == 4'd2) begin
      w_wr_val = w_wr_val & SR_MASK;
    end
  end

  // Register array with synchronous reset.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_regs[0] <= RESET_PC;
      r_regs[1] <= RESET_SP;
    end else if (w_wr_en) begin
      r_regs[regno] <= w_wr_val;
    end
  end

endmodule
